fft_r4_16p_seq: RTL and testbench

//  Sequencer for the 16-point radix-4 FFT datapath (IEEE-754 single, real/imag).
//  - Accepts one complex sample per accepted handshake into the input buffer.
//  - Issues 4 stage-1 butterflies, then 4 stage-2 butterflies, and flags the 4-wide outputs.
//  - Runs as two FSMs (front: load/S1, back: wait/S2), so loading frame n+1 overlaps stage 2 of frame n.

---
 rtl/fft_r4_pkg.sv | 26 ++
 rtl/fft_vld_dly.sv | 34 +++
 rtl/fft_r4_16p_seq.sv | 155 +++++++++++++++
 tb/tb_fft_r4_16p_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_r4_pkg.sv
// Shared sizes and state encodings for the 16-point radix-4 FFT sequencer.
package fft_r4_pkg;

    localparam int N_POINTS   = 16;
    localparam int RADIX      = 4;
    localparam int ADDR_W     = 4;
    localparam int GRP_W      = 2;
    localparam int BF_LAT_MAX = 16;
    localparam int WAIT_W     = $clog2(BF_LAT_MAX + 1);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_POINTS - 1);
    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(RADIX - 1);

    typedef enum logic [1:0] {
        F_LOAD = 2'd0,
        F_HOLD = 2'd1,
        F_S1   = 2'd2
    } front_t;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_WAIT = 2'd1,
        B_S2   = 2'd2
    } back_t;

endpackage

// File: rtl/fft_vld_dly.sv
// Valid + tag shift register matching the butterfly pipeline latency.
module fft_vld_dly #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         vld,
    input  logic [W-1:0] dat,
    output logic         vld_dly,
    output logic [W-1:0] dat_dly
);

    logic [DEPTH-1:0] vld_p;
    logic [W-1:0]     dat_p [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p <= '0;
            for (int i = 0; i < DEPTH; i++) dat_p[i] <= '0;
        end else begin
            vld_p[0] <= vld;
            dat_p[0] <= dat;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
                dat_p[i] <= dat_p[i-1];
            end
        end
    end

    assign vld_dly = vld_p[DEPTH-1];
    assign dat_dly = dat_p[DEPTH-1];

endmodule

// File: rtl/fft_r4_16p_seq.sv
// Sequencer for the 16-point radix-4 FFT: front FSM loads and issues stage 1,
// back FSM waits out the pipeline and issues stage 2, overlapping the next load.
module fft_r4_16p_seq
    import fft_r4_pkg::*;
#(
    parameter int BF_LAT  = 2,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               buf_wr_en,
    output logic [ADDR_W-1:0]  buf_wr_addr,
    output logic               bf1_en,
    output logic [GRP_W-1:0]   bf1_grp,
    output logic               mid_wr_en,
    output logic [GRP_W-1:0]   mid_wr_grp,
    output logic               bf2_en,
    output logic [GRP_W-1:0]   bf2_grp,
    output logic               out_valid,
    output logic [GRP_W-1:0]   out_k,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BF_LAT - 1);

    front_t              front, front_nxt;
    back_t               back, back_nxt;
    logic [ADDR_W-1:0]   load_cnt, load_cnt_nxt;
    logic [GRP_W-1:0]    s1_cnt, s1_cnt_nxt;
    logic [GRP_W-1:0]    s2_cnt, s2_cnt_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [FRAME_W-1:0]  frame_cnt_q;
    logic                accept, back_free, s1_last;
    logic                mid_vld, out_vld;
    logic [GRP_W-1:0]    mid_grp, out_grp;

    assign back_free = (back == B_IDLE) || (back == B_S2 && s2_cnt == GRP_LAST);
    assign s1_last   = (front == F_S1) && (s1_cnt == GRP_LAST);

    // Every output is forced low while reset is held, independent of the
    // registered state, so the reset cycle itself is already quiet.
    assign in_ready    = reset && (front == F_LOAD);
    assign accept      = in_valid && in_ready;
    assign buf_wr_en   = accept;
    assign buf_wr_addr = reset ? load_cnt : '0;
    assign bf1_en      = reset && (front == F_S1);
    assign bf1_grp     = bf1_en ? s1_cnt : '0;
    assign bf2_en      = reset && (back == B_S2);
    assign bf2_grp     = bf2_en ? s2_cnt : '0;
    assign mid_wr_en   = reset && mid_vld;
    assign mid_wr_grp  = mid_wr_en ? mid_grp : '0;
    assign out_valid   = reset && out_vld;
    assign out_k       = out_valid ? out_grp : '0;
    assign frame_done  = out_valid && (out_k == GRP_LAST);
    assign frame_cnt   = reset ? frame_cnt_q : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            front       <= F_LOAD;
            back        <= B_IDLE;
            load_cnt    <= '0;
            s1_cnt      <= '0;
            s2_cnt      <= '0;
            wait_cnt    <= '0;
            frame_cnt_q <= '0;
        end else begin
            front    <= front_nxt;
            back     <= back_nxt;
            load_cnt <= load_cnt_nxt;
            s1_cnt   <= s1_cnt_nxt;
            s2_cnt   <= s2_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (frame_done) frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
        end
    end

    always_comb begin
        front_nxt    = front;
        load_cnt_nxt = load_cnt;
        s1_cnt_nxt   = s1_cnt;
        unique case (front)
            F_LOAD: begin
                if (accept) begin
                    load_cnt_nxt = load_cnt + ADDR_W'(1);
                    if (load_cnt == ADDR_LAST) front_nxt = back_free ? F_S1 : F_HOLD;
                end
            end
            F_HOLD: begin
                if (back_free) front_nxt = F_S1;
            end
            F_S1: begin
                s1_cnt_nxt = s1_cnt + GRP_W'(1);
                if (s1_cnt == GRP_LAST) begin
                    front_nxt    = F_LOAD;
                    load_cnt_nxt = '0;
                    s1_cnt_nxt   = '0;
                end
            end
            default: front_nxt = F_LOAD;
        endcase
    end

    // The wait state spans exactly BF_LAT cycles so the last mid write
    // retires before the first stage-2 read.
    always_comb begin
        back_nxt     = back;
        s2_cnt_nxt   = s2_cnt;
        wait_cnt_nxt = wait_cnt;
        unique case (back)
            B_IDLE: begin
                if (s1_last) begin
                    back_nxt     = B_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            B_WAIT: begin
                wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                if (wait_cnt == WAIT_LAST) begin
                    back_nxt   = B_S2;
                    s2_cnt_nxt = '0;
                end
            end
            B_S2: begin
                s2_cnt_nxt = s2_cnt + GRP_W'(1);
                if (s2_cnt == GRP_LAST) begin
                    back_nxt   = B_IDLE;
                    s2_cnt_nxt = '0;
                end
            end
            default: back_nxt = B_IDLE;
        endcase
    end

    fft_vld_dly #(.DEPTH(BF_LAT), .W(GRP_W)) u_mid_dly (
        .clk     (clk),
        .reset   (reset),
        .vld     (bf1_en),
        .dat     (s1_cnt),
        .vld_dly (mid_vld),
        .dat_dly (mid_grp)
    );

    fft_vld_dly #(.DEPTH(BF_LAT), .W(GRP_W)) u_out_dly (
        .clk     (clk),
        .reset   (reset),
        .vld     (bf2_en),
        .dat     (s2_cnt),
        .vld_dly (out_vld),
        .dat_dly (out_grp)
    );

endmodule

// File: tb/tb_fft_r4_16p_seq.sv
// Scoreboard bench: two sequencers (BF_LAT=2 and 14) share one stimulus stream,
// each checked against a frame-schedule model built from the latency rules.
module tb_fft_r4_16p_seq;

    typedef struct {
        int cyc;
        int grp;
    } ev_t;

    logic clk;
    logic reset;
    logic in_valid;

    logic       rdy      [2];
    logic       wen      [2];
    logic [3:0] waddr    [2];
    logic       en_k     [2][4];
    logic [1:0] grp_k    [2][4];
    logic       fd       [2];
    logic [7:0] fcnt_o   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        fft_r4_16p_seq #(.BF_LAT(gi == 0 ? 2 : 14), .FRAME_W(8)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .in_valid    (in_valid),
            .in_ready    (rdy[gi]),
            .buf_wr_en   (wen[gi]),
            .buf_wr_addr (waddr[gi]),
            .bf1_en      (en_k[gi][0]),
            .bf1_grp     (grp_k[gi][0]),
            .mid_wr_en   (en_k[gi][1]),
            .mid_wr_grp  (grp_k[gi][1]),
            .bf2_en      (en_k[gi][2]),
            .bf2_grp     (grp_k[gi][2]),
            .out_valid   (en_k[gi][3]),
            .out_k       (grp_k[gi][3]),
            .frame_done  (fd[gi]),
            .frame_cnt   (fcnt_o[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    int  ld          [2];
    int  busy_end    [2];
    int  prev_s2_end [2];
    int  fcnt        [2];
    ev_t q [2][4][$];

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 14;
    endfunction

    function automatic string kname(input int k);
        case (k)
            0: return "bf1";
            1: return "mid_wr";
            2: return "bf2";
            default: return "out";
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s lat=%0d cyc=%0d got=%0d expected=%0d", nm, lat(i), cyc, act, exp);
        end
    endtask

    // Model: at each clock edge decide whether a sample was taken and, when a
    // frame completes, schedule every stage event of that frame.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                ld[i]          = 0;
                busy_end[i]    = -1;
                prev_s2_end[i] = -1000;
                for (int k = 0; k < 4; k++) q[i][k].delete();
            end else if (in_valid && cyc > busy_end[i]) begin
                ld[i] = ld[i] + 1;
                if (ld[i] == 16) begin
                    int s1;
                    int s2;
                    ld[i] = 0;
                    s1 = ((cyc > prev_s2_end[i]) ? cyc : prev_s2_end[i]) + 1;
                    s2 = s1 + 4 + lat(i);
                    busy_end[i]    = s1 + 3;
                    prev_s2_end[i] = s2 + 3;
                    for (int g = 0; g < 4; g++) begin
                        q[i][0].push_back('{s1 + g, g});
                        q[i][1].push_back('{s1 + lat(i) + g, g});
                        q[i][2].push_back('{s2 + g, g});
                        q[i][3].push_back('{s2 + lat(i) + g, g});
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    // Monitor: compare the DUT against the model mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                int all;
                all = int'({rdy[i], wen[i], waddr[i], en_k[i][0], grp_k[i][0],
                            en_k[i][1], grp_k[i][1], en_k[i][2], grp_k[i][2],
                            en_k[i][3], grp_k[i][3], fd[i], fcnt_o[i]});
                chk("reset_outputs", i, all, 0);
                fcnt[i] = 0;
                for (int k = 0; k < 4; k++)
                    if (q[i][k].size() > 0 && q[i][k][0].cyc == cyc) void'(q[i][k].pop_front());
            end else begin
                int  exp_rdy;
                int  exp_fd;
                exp_rdy = (cyc > busy_end[i]) ? 1 : 0;
                exp_fd  = 0;
                chk("in_ready", i, int'(rdy[i]), exp_rdy);
                chk("buf_wr_en", i, int'(wen[i]), (in_valid && exp_rdy != 0) ? 1 : 0);
                if (in_valid && exp_rdy != 0) chk("buf_wr_addr", i, int'(waddr[i]), ld[i]);
                for (int k = 0; k < 4; k++) begin
                    int exp_en;
                    int exp_g;
                    exp_en = 0;
                    exp_g  = 0;
                    if (q[i][k].size() > 0 && q[i][k][0].cyc == cyc) begin
                        exp_en = 1;
                        exp_g  = q[i][k][0].grp;
                        void'(q[i][k].pop_front());
                    end
                    chk({kname(k), "_en"}, i, int'(en_k[i][k]), exp_en);
                    if (exp_en != 0) chk({kname(k), "_grp"}, i, int'(grp_k[i][k]), exp_g);
                    if (k == 3 && exp_en != 0 && exp_g == 3) exp_fd = 1;
                end
                chk("frame_done", i, int'(fd[i]), exp_fd);
                chk("frame_cnt", i, int'(fcnt_o[i]), fcnt[i]);
                if (exp_fd != 0) fcnt[i] = (fcnt[i] + 1) % 256;
            end
        end
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            in_valid = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int n);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Single frame on consecutive cycles, then drain.
        drive(1'b1, 16);
        drive(1'b0, 40);

        // Alternating valid: the address only moves on accepted samples.
        for (int j = 0; j < 40; j++) drive((j % 2) == 0, 1);
        drive(1'b0, 40);

        // Continuous valid: back-to-back frames (holds appear at BF_LAT=14).
        drive(1'b1, 70);
        drive(1'b0, 50);

        // Random valid pattern.
        for (int j = 0; j < 250; j++) drive($urandom_range(0, 3) != 0, 1);
        drive(1'b0, 50);

        // Clear any partial frame, then reset while the back end is busy.
        pulse_reset(2);
        drive(1'b1, 16);
        drive(1'b0, 7);
        pulse_reset(1);
        drive(1'b0, 40);
        drive(1'b1, 16);
        drive(1'b0, 19);
        pulse_reset(1);
        drive(1'b0, 40);

        // A full frame after the mid-frame resets.
        drive(1'b1, 16);
        drive(1'b0, 60);

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                chk({kname(k), "_drained"}, i, q[i][k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
